// File: rtl/fp_accum_seq.sv
// Accumulating sequencer for a combinational bf16 add/sub unit: streams elements
// into the adder two cycles apiece and hands back sum, element count and a sticky NaN flag.

package fp_alu_pkg;
  typedef enum logic [0:0] {
    FP_ALU_ADD = 1'b0,
    FP_ALU_SUB = 1'b1
  } fp_alu_op_e;
endpackage

module fp_accum_seq
  import fp_alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_data_i,
  input  logic             in_sub_i,
  input  logic             in_last_i,
  output fp_alu_op_e       add_op_o,
  output logic [15:0]      add_a_o,
  output logic [15:0]      add_b_o,
  input  logic [15:0]      add_c_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [15:0]      res_data_o,
  output logic [CNT_W-1:0] res_count_o,
  output logic             res_nan_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state;
  state_e           state_next;
  logic [15:0]      acc;
  logic [15:0]      b_q;
  logic [CNT_W-1:0] cnt;
  logic             nan_q;
  logic             last_q;
  fp_alu_op_e       op_q;

  logic             seq_start;
  logic             in_fire;
  logic             add_commit;
  logic             c_is_nan;

  // Abort has priority over every handshake and over start.
  assign seq_start  = (state == IDLE) && start_i && !abort_i;
  assign in_fire    = (state == RUN) && in_valid_i && !abort_i;
  assign add_commit = (state == ADD) && !abort_i;
  assign c_is_nan   = (add_c_i[14:7] == 8'hFF) && (add_c_i[6:0] != 7'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort_i) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start_i)     state_next = RUN;
        RUN:  if (in_valid_i)  state_next = ADD;
        ADD:  state_next = last_q ? DONE : RUN;
        DONE: if (res_ready_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Element capture: operands are held in registers so the adder inputs stay stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_q    <= 16'h0000;
      op_q   <= FP_ALU_ADD;
      last_q <= 1'b0;
    end else if (in_fire) begin
      b_q    <= in_data_i;
      op_q   <= in_sub_i ? FP_ALU_SUB : FP_ALU_ADD;
      last_q <= in_last_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc   <= 16'h0000;
      cnt   <= '0;
      nan_q <= 1'b0;
    end else if (seq_start) begin
      acc   <= 16'h0000;
      cnt   <= '0;
      nan_q <= 1'b0;
    end else if (add_commit) begin
      acc   <= add_c_i;
      nan_q <= nan_q | c_is_nan;
      if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign add_a_o     = acc;
  assign add_b_o     = b_q;
  assign add_op_o    = op_q;

  assign in_ready_o  = (state == RUN) && !abort_i;
  assign res_valid_o = (state == DONE);
  assign res_data_o  = acc;
  assign res_count_o = cnt;
  assign res_nan_o   = nan_q;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq with a real-valued bf16 adder model on the adder port.

module tb_fp_accum_seq;
  import fp_alu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, abort_i;
  logic        in_valid_i, in_ready_o;
  logic [15:0] in_data_i;
  logic        in_sub_i, in_last_i;
  fp_alu_op_e  add_op_o;
  logic [15:0] add_a_o, add_b_o, add_c_i;
  logic        res_valid_o, res_ready_i;
  logic [15:0] res_data_o;
  logic [7:0]  res_count_o;
  logic        res_nan_o, busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               n;
    logic [3:0][15:0] data;
    logic [3:0]       sub;
    logic [15:0]      exp_data;
    logic [7:0]       exp_cnt;
    logic             exp_nan;
  } vec_t;

  vec_t vecs[6];

  fp_accum_seq #(.CNT_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_sub_i(in_sub_i), .in_last_i(in_last_i), .add_op_o(add_op_o),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_c_i(add_c_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_count_o(res_count_o), .res_nan_o(res_nan_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic real bf_to_real(input logic [15:0] x);
    real v;
    if (x[14:7] == 8'd0) return 0.0;
    v = (1.0 + real'(int'(x[6:0])) / 128.0) * (2.0 ** real'(int'(x[14:7]) - 127));
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] real_to_bf(input real r);
    real a;
    int  e;
    int  m;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = int'(a * 128.0 - 128.0);
    if (m >= 128) begin m = 0; e++; end
    return {s, 8'(e + 127), 7'(m)};
  endfunction

  function automatic logic [15:0] bf16_addsub(input logic [15:0] a, input logic [15:0] b,
                                              input logic sub);
    if ((a[14:7] == 8'hFF && a[6:0] != 0) || (b[14:7] == 8'hFF && b[6:0] != 0))
      return 16'h7FC0;
    return real_to_bf(sub ? bf_to_real(a) - bf_to_real(b) : bf_to_real(a) + bf_to_real(b));
  endfunction

  assign add_c_i = bf16_addsub(add_a_o, add_b_o, add_op_o == FP_ALU_SUB);

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_seq();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check_output("busy_after_start", 16'(busy_o), 16'd1);
  endtask

  task automatic apply_stimulus(input logic [15:0] d, input logic s, input logic l);
    int guard = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_sub_i   = s;
    in_last_i  = l;
    @(negedge clk_i);
    while (!in_ready_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    if (!in_ready_o) check_output("in_ready_timeout", 16'(in_ready_o), 16'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  // Called just after the last element's handshake edge.
  task automatic collect_result(input string tag, input logic [15:0] exp_data,
                                input logic [7:0] exp_cnt, input logic exp_nan, input int hold);
    @(negedge clk_i);
    check_output({tag, "_valid_early"}, 16'(res_valid_o), 16'd0);
    @(negedge clk_i);
    check_output({tag, "_valid"}, 16'(res_valid_o), 16'd1);
    check_output({tag, "_data"}, res_data_o, exp_data);
    check_output({tag, "_count"}, 16'(res_count_o), 16'(exp_cnt));
    check_output({tag, "_nan"}, 16'(res_nan_o), 16'(exp_nan));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk_i);
      check_output({tag, "_hold_valid"}, 16'(res_valid_o), 16'd1);
      check_output({tag, "_hold_data"}, res_data_o, exp_data);
      check_output({tag, "_hold_in_ready"}, 16'(in_ready_o), 16'd0);
    end
    res_ready_i = 1'b1;
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    @(negedge clk_i);
    check_output({tag, "_valid_cleared"}, 16'(res_valid_o), 16'd0);
    check_output({tag, "_idle"}, 16'(busy_o), 16'd0);
  endtask

  task automatic run_vec(input int idx, input int hold);
    start_seq();
    for (int i = 0; i < vecs[idx].n; i++)
      apply_stimulus(vecs[idx].data[i], vecs[idx].sub[i], i == vecs[idx].n - 1);
    collect_result($sformatf("vec%0d", idx), vecs[idx].exp_data, vecs[idx].exp_cnt,
                   vecs[idx].exp_nan, hold);
  endtask

  initial begin
    // Element 0 is the rightmost data word / sub bit.
    vecs[0] = '{3, {16'h0000, 16'h3F00, 16'h4000, 16'h3F80}, 4'b0000, 16'h4060, 8'd3, 1'b0};
    vecs[1] = '{2, {16'h0000, 16'h0000, 16'h3F80, 16'h4040}, 4'b0010, 16'h4000, 8'd2, 1'b0};
    vecs[2] = '{2, {16'h0000, 16'h0000, 16'h3F80, 16'h7FC0}, 4'b0000, 16'h7FC0, 8'd2, 1'b1};
    vecs[3] = '{1, {16'h0000, 16'h0000, 16'h0000, 16'h3F80}, 4'b0001, 16'hBF80, 8'd1, 1'b0};
    vecs[4] = '{4, {16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80}, 4'b0000, 16'h4080, 8'd4, 1'b0};
    vecs[5] = '{3, {16'h0000, 16'h3F80, 16'h4000, 16'h4000}, 4'b0110, 16'hBF80, 8'd3, 1'b0};

    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; in_valid_i = 1'b0;
    in_data_i = 16'h0; in_sub_i = 1'b0; in_last_i = 1'b0; res_ready_i = 1'b0;
    #12;
    check_output("rst_busy", 16'(busy_o), 16'd0);
    check_output("rst_in_ready", 16'(in_ready_o), 16'd0);
    check_output("rst_res_valid", 16'(res_valid_o), 16'd0);
    check_output("rst_add_op", 16'(add_op_o), 16'(FP_ALU_ADD));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int v = 0; v < 6; v++) run_vec(v, 0);
    run_vec(0, 5);

    // Abort during RUN after two elements, concurrent with an offered element.
    start_seq();
    apply_stimulus(16'h3F80, 1'b0, 1'b0);
    apply_stimulus(16'h4000, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    abort_i = 1'b1; in_valid_i = 1'b1; in_data_i = 16'h4040;
    #1;
    check_output("abort_in_ready", 16'(in_ready_o), 16'd0);
    @(posedge clk_i); #1;
    abort_i = 1'b0; in_valid_i = 1'b0;
    check_output("abort_idle", 16'(busy_o), 16'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check_output("abort_no_result", 16'(res_valid_o), 16'd0);
    end
    @(posedge clk_i); #1;
    start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    check_output("abort_beats_start", 16'(busy_o), 16'd0);
    start_seq();
    apply_stimulus(16'h3F80, 1'b0, 1'b1);
    collect_result("after_abort", 16'h3F80, 8'd1, 1'b0, 0);

    // Count saturation at 255.
    start_seq();
    for (int i = 0; i < 260; i++) apply_stimulus(16'h0000, 1'b0, i == 259);
    collect_result("sat", 16'h0000, 8'd255, 1'b0, 0);

    // Asynchronous reset while in ADD with a subtract pending.
    start_seq();
    apply_stimulus(16'h3F80, 1'b0, 1'b0);
    apply_stimulus(16'h4000, 1'b1, 1'b0);
    check_output("add_a_pre", add_a_o, 16'h3F80);
    check_output("add_b_pre", add_b_o, 16'h4000);
    check_output("add_op_pre", 16'(add_op_o), 16'(FP_ALU_SUB));
    rst_ni = 1'b0;
    #1;
    check_output("arst_busy", 16'(busy_o), 16'd0);
    check_output("arst_add_a", add_a_o, 16'h0000);
    check_output("arst_add_b", add_b_o, 16'h0000);
    check_output("arst_add_op", 16'(add_op_o), 16'(FP_ALU_ADD));
    check_output("arst_res_data", res_data_o, 16'h0000);
    check_output("arst_res_count", 16'(res_count_o), 16'd0);
    check_output("arst_res_nan", 16'(res_nan_o), 16'd0);
    check_output("arst_res_valid", 16'(res_valid_o), 16'd0);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    check_output("arst_start_ignored", 16'(busy_o), 16'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_output("post_rst_idle", 16'(busy_o), 16'd0);
    run_vec(1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
